// File: rtl/ps2_pkg.sv
// Shared scan-code constants, sequencer state encoding and event record for
// the PS/2 keyboard sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  localparam int ERR_W = 4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    GAP    = 2'd1,
    DECODE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } kbd_evt_t;

  // Saturating add of up to two error sources in one cycle.
  function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] cnt,
                                                   input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 receiver-FIFO sequencer: pops scan-code bytes, folds E0/F0 prefixes into
// key events, tracks the held key, filters typematic repeats, counts presses/errors.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  output logic             kbd_nextdata_n,
  input  logic             kbd_overflow,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic [3:0]       err_cnt
);

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             evt_valid_q, evt_valid_d;
  kbd_evt_t         evt_q, evt_d;
  logic             held_valid_q, held_valid_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic [3:0]       err_q, err_d;
  logic             ovf_q;

  logic pop;
  logic err_byte;
  logic held_match;

  always_comb begin
    // NOTE: every signal gets its default before the case so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    byte_d       = byte_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    evt_valid_d  = evt_valid_q;
    evt_d        = evt_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    press_d      = press_q;
    pop          = 1'b0;
    err_byte     = 1'b0;
    held_match   = held_valid_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    case (state_q)
      FETCH: begin
        if (kbd_ready) begin
          pop     = 1'b1;
          byte_d  = kbd_data;
          state_d = GAP;
        end
      end

      // Dead cycle: lets the receiver retire the popped byte before we look again.
      GAP: state_d = DECODE;

      DECODE: begin
        state_d = FETCH;
        if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == SC_ERR0 || byte_q == SC_ERR1) begin
          err_byte = 1'b1;
          ext_d    = 1'b0;
          brk_d    = 1'b0;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          evt_d = '{code: byte_q, ext: ext_q, brk: brk_q, rpt: 1'b0};
          if (!brk_q && held_match) begin
            // Typematic repeat of the held key: never re-counted, optionally dropped.
            if (!SUPPRESS_REPEAT) begin
              evt_d.rpt   = 1'b1;
              evt_valid_d = 1'b1;
              state_d     = EMIT;
            end
          end else begin
            if (!brk_q) begin
              held_valid_d = 1'b1;
              held_code_d  = byte_q;
              held_ext_d   = ext_q;
              press_d      = press_q + 1'b1;
            end else if (held_match) begin
              held_valid_d = 1'b0;
            end
            evt_valid_d = 1'b1;
            state_d     = EMIT;
          end
        end
      end

      EMIT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    err_d = err_sat_add(err_q, {1'b0, err_byte} + {1'b0, kbd_overflow & ~ovf_q});
  end

  // Gated by clrn so the FIFO is never popped while the sequencer is held in reset.
  assign kbd_nextdata_n = ~(pop & clrn);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= FETCH;
      byte_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_q        <= '0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      press_q      <= '0;
      err_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      evt_valid_q  <= evt_valid_d;
      evt_q        <= evt_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      press_q      <= press_d;
      err_q        <= err_d;
      ovf_q        <= kbd_overflow;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_q.code;
  assign evt_ext    = evt_q.ext;
  assign evt_break  = evt_q.brk;
  assign evt_repeat = evt_q.rpt;
  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign held_ext   = held_ext_q;
  assign press_cnt  = press_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: two lanes (repeat suppression on / off) fed the same byte
// stream, each checked against a byte-level decode model and hand-computed literals.
module tb_ps2_kbd_ctrl;

  localparam int NL    = 2;   // lane 0: SUPPRESS_REPEAT=1, lane 1: SUPPRESS_REPEAT=0
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ev_t;

  typedef struct packed {
    ev_t        ev;
    logic       hv;
    logic [7:0] hc;
    logic       he;
    logic [7:0] press;
  } exp_t;

  logic clk          = 1'b0;
  logic clrn         = 1'b1;
  logic evt_ready    = 1'b1;
  logic kbd_overflow = 1'b0;

  logic       kbd_ready [NL] = '{1'b0, 1'b0};
  logic [7:0] kbd_data  [NL] = '{8'h00, 8'h00};
  logic       kbd_nextdata_n [NL];
  logic       evt_valid  [NL];
  logic [7:0] evt_code   [NL];
  logic       evt_ext    [NL];
  logic       evt_break  [NL];
  logic       evt_repeat [NL];
  logic       held_valid [NL];
  logic [7:0] held_code  [NL];
  logic       held_ext   [NL];
  logic [7:0] press_cnt  [NL];
  logic [3:0] err_cnt    [NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    ps2_kbd_ctrl #(.CNT_W(8), .SUPPRESS_REPEAT(g == 0)) u_dut (
      .clk           (clk),
      .clrn          (clrn),
      .kbd_ready     (kbd_ready[g]),
      .kbd_data      (kbd_data[g]),
      .kbd_nextdata_n(kbd_nextdata_n[g]),
      .kbd_overflow  (kbd_overflow),
      .evt_valid     (evt_valid[g]),
      .evt_ready     (evt_ready),
      .evt_code      (evt_code[g]),
      .evt_ext       (evt_ext[g]),
      .evt_break     (evt_break[g]),
      .evt_repeat    (evt_repeat[g]),
      .held_valid    (held_valid[g]),
      .held_code     (held_code[g]),
      .held_ext      (held_ext[g]),
      .press_cnt     (press_cnt[g]),
      .err_cnt       (err_cnt[g])
    );
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h at %0t", name, lane, act, exp, $time);
  endtask

  // Receiver FIFO model, one per lane.
  logic [7:0] fifo_mem [NL][DEPTH];
  int         f_wr [NL] = '{0, 0};
  int         f_rd [NL] = '{0, 0};

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      int r;
      r = f_rd[l];
      if (!kbd_nextdata_n[l] && (f_rd[l] != f_wr[l])) r = r + 1;
      f_rd[l]      <= r;
      kbd_ready[l] <= (r != f_wr[l]);
      kbd_data[l]  <= fifo_mem[l][r % DEPTH];
    end
  end

  // Byte-level decode model and expected-event queues.
  logic       m_ext [NL], m_brk [NL], m_hv [NL], m_he [NL];
  logic [7:0] m_hc [NL], m_press [NL];
  int         m_err [NL];
  exp_t       exp_mem [NL][DEPTH];
  int         e_wr [NL] = '{0, 0};
  int         e_rd [NL] = '{0, 0};

  function automatic void model_byte(input int l, input logic [7:0] b);
    exp_t e;
    logic same;
    if (b == 8'hE0) m_ext[l] = 1'b1;
    else if (b == 8'hF0) m_brk[l] = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_err[l] = (m_err[l] < 15) ? m_err[l] + 1 : 15;
      m_ext[l] = 1'b0;
      m_brk[l] = 1'b0;
    end else begin
      same      = m_hv[l] && (m_hc[l] == b) && (m_he[l] == m_ext[l]);
      e.ev.code = b;
      e.ev.ext  = m_ext[l];
      e.ev.brk  = m_brk[l];
      e.ev.rpt  = !m_brk[l] && same;
      if (!m_brk[l] && !same) begin
        m_hv[l]    = 1'b1;
        m_hc[l]    = b;
        m_he[l]    = m_ext[l];
        m_press[l] = m_press[l] + 8'd1;
      end else if (m_brk[l] && same) begin
        m_hv[l] = 1'b0;
      end
      e.hv     = m_hv[l];
      e.hc     = m_hc[l];
      e.he     = m_he[l];
      e.press  = m_press[l];
      m_ext[l] = 1'b0;
      m_brk[l] = 1'b0;
      if (!(e.ev.rpt && l == 0)) begin
        exp_mem[l][e_wr[l] % DEPTH] = e;
        e_wr[l]++;
      end
    end
  endfunction

  // Per-cycle compare process.
  int   ncyc = 0;
  int   last_pop [NL] = '{0, 0};
  logic prev_valid [NL] = '{1'b0, 1'b0};
  logic prev_stall [NL] = '{1'b0, 1'b0};
  ev_t  saved [NL];
  ev_t  last_evt [NL];
  int   xfer_cnt [NL] = '{0, 0};

  always @(negedge clk) begin
    ev_t  cur;
    exp_t e;
    ncyc++;
    for (int l = 0; l < NL; l++) begin
      cur = {evt_code[l], evt_ext[l], evt_break[l], evt_repeat[l]};
      if (!clrn) begin
        check("no_pop_in_reset", l, kbd_nextdata_n[l], 1);
        prev_valid[l] = 1'b0;
        prev_stall[l] = 1'b0;
      end else begin
        if (!kbd_nextdata_n[l]) begin
          check("pop_fifo_nonempty", l, (f_wr[l] != f_rd[l]), 1);
          check("no_pop_while_event", l, evt_valid[l], 0);
          last_pop[l] = ncyc;
        end
        if (evt_valid[l] && !prev_valid[l]) check("evt_latency", l, ncyc - last_pop[l], 3);
        if (prev_stall[l]) begin
          check("stall_valid", l, evt_valid[l], 1);
          check("stall_stable", l, cur, saved[l]);
        end
        if (evt_valid[l] && evt_ready) begin
          xfer_cnt[l]++;
          last_evt[l] = cur;
          check("event_expected", l, (e_wr[l] != e_rd[l]), 1);
          if (e_wr[l] != e_rd[l]) begin
            e = exp_mem[l][e_rd[l] % DEPTH];
            e_rd[l]++;
            check("evt_fields", l, cur, e.ev);
            check("evt_held_valid", l, held_valid[l], e.hv);
            if (e.hv) begin
              check("evt_held_code", l, held_code[l], e.hc);
              check("evt_held_ext", l, held_ext[l], e.he);
            end
            check("evt_press_cnt", l, press_cnt[l], e.press);
          end
        end
        prev_valid[l] = evt_valid[l];
        prev_stall[l] = evt_valid[l] && !evt_ready;
        saved[l]      = cur;
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    for (int l = 0; l < NL; l++) begin
      fifo_mem[l][f_wr[l] % DEPTH] = b;
      f_wr[l]++;
      model_byte(l, b);
    end
  endtask

  task automatic set_ovf(input logic v);
    if (v && !kbd_overflow)
      for (int l = 0; l < NL; l++) m_err[l] = (m_err[l] < 15) ? m_err[l] + 1 : 15;
    kbd_overflow = v;
  endtask

  function automatic bit lanes_idle();
    bit idle;
    idle = 1'b1;
    for (int l = 0; l < NL; l++)
      if ((f_rd[l] != f_wr[l]) || (e_rd[l] != e_wr[l]) || evt_valid[l]) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_idle();
    int quiet;
    int budget;
    quiet  = 0;
    budget = 0;
    while (quiet < 6 && budget < 500) begin
      step(1);
      budget++;
      if (lanes_idle()) quiet++;
      else quiet = 0;
    end
    check("idle_reached", 0, (quiet >= 6), 1);
  endtask

  task automatic check_state();
    for (int l = 0; l < NL; l++) begin
      check("held_valid", l, held_valid[l], m_hv[l]);
      if (m_hv[l]) begin
        check("held_code", l, held_code[l], m_hc[l]);
        check("held_ext", l, held_ext[l], m_he[l]);
      end
      check("press_cnt", l, press_cnt[l], m_press[l]);
      check("err_cnt", l, err_cnt[l], m_err[l]);
    end
  endtask

  task automatic do_reset();
    step(1);
    clrn = 1'b0;
    step(2);
    for (int l = 0; l < NL; l++) begin
      f_wr[l]    = f_rd[l];
      e_wr[l]    = e_rd[l];
      m_ext[l]   = 1'b0;
      m_brk[l]   = 1'b0;
      m_hv[l]    = 1'b0;
      m_he[l]    = 1'b0;
      m_hc[l]    = 8'h00;
      m_press[l] = 8'h00;
      m_err[l]   = 0;
      check("rst_evt_valid", l, evt_valid[l], 0);
      check("rst_held_valid", l, held_valid[l], 0);
      check("rst_held_code", l, held_code[l], 8'h00);
      check("rst_press_cnt", l, press_cnt[l], 8'h00);
      check("rst_err_cnt", l, err_cnt[l], 4'h0);
      check("rst_nextdata_n", l, kbd_nextdata_n[l], 1);
    end
    step(1);
    clrn = 1'b1;
    step(1);
  endtask

  initial begin
    int p0;
    int x0;
    int x1;
    #2 clrn = 1'b0;

    // Single make code.
    do_reset();
    p0 = f_rd[0];
    push(8'h1C);
    wait_idle();
    check_state();
    check("t1_pops", 0, f_rd[0] - p0, 1);
    check("t1_event", 0, last_evt[0], {8'h1C, 1'b0, 1'b0, 1'b0});
    check("t1_held_code", 0, held_code[0], 8'h1C);
    check("t1_press_cnt", 0, press_cnt[0], 8'd1);

    // Make then break of the same key.
    do_reset();
    p0 = f_rd[0];
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle();
    check_state();
    check("t2_pops", 0, f_rd[0] - p0, 3);
    check("t2_held_valid", 0, held_valid[0], 0);
    check("t2_press_cnt", 0, press_cnt[0], 8'd1);
    check("t2_event", 0, last_evt[0], {8'h1C, 1'b0, 1'b1, 1'b0});

    // Prefix order does not matter.
    do_reset();
    push(8'hE0); push(8'hF0); push(8'h74);
    wait_idle();
    check("t3_e0f0_event", 0, last_evt[0], {8'h74, 1'b1, 1'b1, 1'b0});
    push(8'hF0); push(8'hE0); push(8'h74);
    wait_idle();
    check("t3_f0e0_event", 0, last_evt[0], {8'h74, 1'b1, 1'b1, 1'b0});
    check_state();

    // Typematic repeats.
    do_reset();
    x0 = xfer_cnt[0];
    x1 = xfer_cnt[1];
    push(8'h1C); push(8'h1C); push(8'h1C);
    wait_idle();
    check_state();
    check("t4_events_suppressed", 0, xfer_cnt[0] - x0, 1);
    check("t4_events_emitted", 1, xfer_cnt[1] - x1, 3);
    check("t4_press_cnt", 1, press_cnt[1], 8'd1);
    check("t4_last_repeat", 1, last_evt[1], {8'h1C, 1'b0, 1'b0, 1'b1});

    // Backpressure: event held, no further pops while stalled.
    do_reset();
    evt_ready = 1'b0;
    push(8'h1C); push(8'h32); push(8'h21);
    step(20);
    for (int l = 0; l < NL; l++) begin
      check("t5_fifo_left", l, f_wr[l] - f_rd[l], 2);
      check("t5_evt_pending", l, evt_valid[l], 1);
      check("t5_code_held", l, evt_code[l], 8'h1C);
    end
    evt_ready = 1'b1;
    wait_idle();
    check_state();
    check("t5_press_cnt", 0, press_cnt[0], 8'd3);

    // Error byte plus overflow rising edge.
    do_reset();
    push(8'hFF);
    wait_idle();
    set_ovf(1'b1);
    wait_idle();
    check_state();
    check("t6_err_cnt", 0, err_cnt[0], 4'd2);
    set_ovf(1'b0);
    step(2);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) push(8'hFF);
    wait_idle();
    check_state();
    check("t7_err_sat", 0, err_cnt[0], 4'hF);

    // Reset discards a pending event and a partial prefix.
    do_reset();
    evt_ready = 1'b0;
    push(8'h5A);
    step(8);
    check("t8_evt_pending", 0, evt_valid[0], 1);
    do_reset();
    evt_ready = 1'b1;
    push(8'hE0);
    step(8);
    do_reset();
    push(8'h1C);
    wait_idle();
    check_state();
    check("t8_event_no_ext", 0, last_evt[0], {8'h1C, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
